// File: rtl/text_typewriter_if.sv
// Letter-source / renderer bundle for text_typewriter: control pulses, source text and
// revealed text with progress status.
interface text_typewriter_if #(
    parameter int unsigned NUM_LETTERS = 10
);
    logic                     start;
    logic                     skip;
    logic                     startOfFrame;
    logic [5*NUM_LETTERS-1:0] letters_in;
    logic [5*NUM_LETTERS-1:0] letters_out;
    logic [3:0]               visible_count;
    logic                     busy;
    logic                     done;

    modport master (
        output start, skip, startOfFrame, letters_in,
        input  letters_out, visible_count, busy, done
    );

    modport slave (
        input  start, skip, startOfFrame, letters_in,
        output letters_out, visible_count, busy, done
    );
endinterface

// File: rtl/text_typewriter.sv
// Typewriter reveal of a latched letter array, one letter per TICKS_PER_LETTER frames.
// Optional blinking cursor at the next position: define TEXT_TYPEWRITER_CURSOR_BLINK_EN.
module text_typewriter #(
    parameter int unsigned NUM_LETTERS      = 10,
    parameter int unsigned TICKS_PER_LETTER = 8,
    parameter logic [4:0]  BLANK_CODE       = 5'd0,
    parameter logic [4:0]  CURSOR_CODE      = 5'd31
) (
    input logic               clk,
    input logic               reset,
    text_typewriter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StTyping, StDone} state_e;

    localparam logic [3:0] NumL    = 4'(NUM_LETTERS);
    localparam logic [7:0] TickMax = 8'(TICKS_PER_LETTER - 1);

    state_e                        state_q, state_d;
    logic [3:0]                    vis_q, vis_d;
    logic [7:0]                    tick_q, tick_d;
    logic [NUM_LETTERS-1:0][4:0]   text_q, text_d;
    logic [NUM_LETTERS-1:0][4:0]   out_q, out_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          cur_blank;
    logic                          adv;

`ifdef TEXT_TYPEWRITER_CURSOR_BLINK_EN
    logic [3:0] cursor_q, cursor_d;

    always_comb begin
        cursor_d = cursor_q;
        if (bus.start) begin
            cursor_d = 4'd0;
        end else if (bus.startOfFrame) begin
            cursor_d = cursor_q + 4'd1;
        end
    end
`endif

    always_comb begin
        cur_blank = 1'b0;
        for (int i = 0; i < int'(NUM_LETTERS); i++) begin
            if (4'(i) == vis_q && text_q[i] == BLANK_CODE) cur_blank = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        vis_d   = vis_q;
        tick_d  = tick_q;
        text_d  = text_q;
        done_d  = 1'b0;
        adv     = 1'b0;
        if (bus.start) begin
            text_d  = bus.letters_in;
            vis_d   = 4'd0;
            tick_d  = 8'd0;
            state_d = StTyping;
        end else if (state_q == StTyping) begin
            if (bus.skip) begin
                vis_d   = NumL;
                state_d = StDone;
                done_d  = 1'b1;
            end else begin
                // Spaces advance immediately; the frame pacer keeps running regardless.
                adv = cur_blank;
                if (bus.startOfFrame) begin
                    if (tick_q >= TickMax) begin
                        tick_d = 8'd0;
                        adv    = 1'b1;
                    end else begin
                        tick_d = tick_q + 8'd1;
                    end
                end
                if (adv) begin
                    if (vis_q >= NumL - 4'd1) begin
                        vis_d   = NumL;
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        vis_d = vis_q + 4'd1;
                    end
                end
            end
        end
        busy_d = (state_d == StTyping);
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_LETTERS); i++) begin
            out_d[i] = (4'(i) < vis_q) ? text_q[i] : BLANK_CODE;
`ifdef TEXT_TYPEWRITER_CURSOR_BLINK_EN
            if (state_q == StTyping && 4'(i) == vis_q && cursor_q[3]) out_d[i] = CURSOR_CODE;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            vis_q   <= 4'd0;
            tick_q  <= 8'd0;
            text_q  <= {NUM_LETTERS{BLANK_CODE}};
            out_q   <= {NUM_LETTERS{BLANK_CODE}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef TEXT_TYPEWRITER_CURSOR_BLINK_EN
            cursor_q <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            vis_q   <= vis_d;
            tick_q  <= tick_d;
            text_q  <= text_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef TEXT_TYPEWRITER_CURSOR_BLINK_EN
            cursor_q <= cursor_d;
`endif
        end
    end

    assign bus.letters_out   = out_q;
    assign bus.visible_count = vis_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_text_typewriter.sv
// Randomized and directed checks of text_typewriter against a frame/letter-level model.
module tb_text_typewriter;

    localparam int N = 10;
    localparam int T = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   n_done = 0;

    text_typewriter_if #(.NUM_LETTERS(N)) ifc ();

    text_typewriter #(
        .NUM_LETTERS     (N),
        .TICKS_PER_LETTER(T),
        .BLANK_CODE      (5'd0),
        .CURSOR_CODE     (5'd31)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc)
    );

    always #5 clk = ~clk;

    // Model: 0 idle, 1 typing, 2 done
    int m_state, m_vis, m_tick, m_cursor;
    int m_text[N];
    int m_out[N];
    bit m_busy, m_done;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = 0; m_vis = 0; m_tick = 0; m_cursor = 0;
        m_busy = 0; m_done = 0;
        for (int i = 0; i < N; i++) begin
            m_text[i] = 0;
            m_out[i]  = 0;
        end
    endfunction

    function automatic void model_clock(input bit st, input bit sk, input bit sf,
                                        input logic [5*N-1:0] lin);
        bit adv;
        // Renderer view reflects the state before this edge.
        for (int i = 0; i < N; i++) begin
            m_out[i] = (i < m_vis) ? m_text[i] : 0;
`ifdef TEXT_TYPEWRITER_CURSOR_BLINK_EN
            if (m_state == 1 && i == m_vis && m_cursor >= 8) m_out[i] = 31;
`endif
        end
        m_done = 0;
        if (st) begin
            for (int i = 0; i < N; i++) m_text[i] = int'(lin[5*i +: 5]);
            m_vis = 0; m_tick = 0; m_state = 1;
        end else if (m_state == 1) begin
            if (sk) begin
                m_vis = N; m_state = 2; m_done = 1;
            end else begin
                adv = (m_text[m_vis] == 0);
                if (sf) begin
                    m_tick = m_tick + 1;
                    if (m_tick == T) begin
                        m_tick = 0;
                        adv = 1;
                    end
                end
                if (adv) m_vis = m_vis + 1;
                if (m_vis == N) begin
                    m_state = 2; m_done = 1;
                end
            end
        end
        if (st) m_cursor = 0;
        else if (sf) m_cursor = (m_cursor + 1) % 16;
        m_busy = (m_state == 1);
    endfunction

    function automatic logic [5*N-1:0] model_out();
        logic [5*N-1:0] v;
        for (int i = 0; i < N; i++) v[5*i +: 5] = 5'(m_out[i]);
        return v;
    endfunction

    task automatic step(input bit st, input bit sk, input bit sf);
        logic [5*N-1:0] lin;
        ifc.start = st; ifc.skip = sk; ifc.startOfFrame = sf;
        lin = ifc.letters_in;
        @(posedge clk);
        model_clock(st, sk, sf, lin);
        #1;
        ifc.start = 0; ifc.skip = 0; ifc.startOfFrame = 0;
        @(negedge clk);
        check("visible_count", 64'(ifc.visible_count), 64'(m_vis));
        check("busy", 64'(ifc.busy), 64'(m_busy));
        check("done", 64'(ifc.done), 64'(m_done));
        check("letters_out", 64'(ifc.letters_out), 64'(model_out()));
        if (ifc.done) n_done++;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            step(0, 0, 1);
            step(0, 0, 0);
            step(0, 0, 0);
        end
    endtask

    task automatic run_until_vis(input int target);
        for (int k = 0; k < 300 && int'(ifc.visible_count) != target; k++) step(0, 0, (k % 3) == 0);
        check("reach_vis", 64'(ifc.visible_count), 64'(target));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1;
        #1;
        check("rst_letters", 64'(ifc.letters_out), 64'd0);
        check("rst_vis", 64'(ifc.visible_count), 64'd0);
        check("rst_busy", 64'(ifc.busy), 64'd0);
        check("rst_done", 64'(ifc.done), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 0;
    endtask

    function automatic logic [5*N-1:0] seq_letters();
        logic [5*N-1:0] v;
        for (int i = 0; i < N; i++) v[5*i +: 5] = 5'(i + 1);
        return v;
    endfunction

    logic [5*N-1:0] latched;

    initial begin
        ifc.start = 0; ifc.skip = 0; ifc.startOfFrame = 0; ifc.letters_in = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check("init_letters", 64'(ifc.letters_out), 64'd0);
        check("init_busy", 64'(ifc.busy), 64'd0);
        reset = 0;

        // No start: idle for 100 frames, never a done pulse.
        n_done = 0;
        for (int k = 0; k < 100; k++) begin
            step(0, 0, 1);
            step(0, 0, 0);
        end
        check("idle_done_cnt", 64'(n_done), 64'd0);
        step(0, 1, 0);
        check("idle_skip_done", 64'(ifc.done), 64'd0);

        // Letters 1..10, paced typing.
        ifc.letters_in = seq_letters();
        step(1, 0, 0);
        n_done = 0;
        frames(1);
        check("seq_vis_f1", 64'(ifc.visible_count), 64'd0);
        step(0, 0, 1);
        check("seq_vis_f2", 64'(ifc.visible_count), 64'd1);
        step(0, 0, 0);
        check("seq_out0", 64'(ifc.letters_out[4:0]), 64'd1);
        ifc.letters_in = '1;  // must not disturb the latched text
        frames(18);
        check("seq_vis_end", 64'(ifc.visible_count), 64'd10);
        check("seq_busy_end", 64'(ifc.busy), 64'd0);
        check("seq_out_all", 64'(ifc.letters_out), 64'(seq_letters()));
        check("seq_done_cnt", 64'(n_done), 64'd1);

        // Blanks at index 1 and 2 each cost one clock.
        latched = seq_letters();
        latched[9:5] = 5'd0; latched[14:10] = 5'd0; latched[4:0] = 5'd3; latched[19:15] = 5'd4;
        ifc.letters_in = latched;
        step(1, 0, 0);
        frames(1);
        step(0, 0, 1);
        check("sp_vis1", 64'(ifc.visible_count), 64'd1);
        step(0, 0, 0);
        check("sp_vis2", 64'(ifc.visible_count), 64'd2);
        step(0, 0, 0);
        check("sp_vis3", 64'(ifc.visible_count), 64'd3);
        frames(1);
        check("sp_vis3_hold", 64'(ifc.visible_count), 64'd3);
        step(0, 0, 1);
        check("sp_vis4", 64'(ifc.visible_count), 64'd4);

        // Skip at visible_count 4.
        n_done = 0;
        step(0, 1, 0);
        check("skip_vis", 64'(ifc.visible_count), 64'd10);
        check("skip_done", 64'(ifc.done), 64'd1);
        step(0, 0, 0);
        check("skip_out", 64'(ifc.letters_out), 64'(latched));
        frames(4);
        check("skip_done_cnt", 64'(n_done), 64'd1);

        // Start together with skip at visible_count 4.
        ifc.letters_in = seq_letters();
        step(1, 0, 0);
        run_until_vis(4);
        step(1, 1, 1);
        check("ss_vis", 64'(ifc.visible_count), 64'd0);
        check("ss_done", 64'(ifc.done), 64'd0);
        check("ss_busy", 64'(ifc.busy), 64'd1);

        // Asynchronous reset at visible_count 6.
        run_until_vis(6);
        do_reset();

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            if (c % 50 == 0) begin
                logic [5*N-1:0] v;
                for (int i = 0; i < N; i++)
                    v[5*i +: 5] = ($urandom_range(0, 9) < 3) ? 5'd0 : 5'($urandom_range(1, 31));
                ifc.letters_in = v;
            end
            if (c % 1500 == 1499) do_reset();
            else step($urandom_range(0, 59) == 0, $urandom_range(0, 79) == 0,
                      $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
